uart_rx: RTL and testbench

Serial receiver for the keyboard's UART link. It oversamples the synchronised `rx` line at the system clock, frames 8N1 characters (LSB first), and delivers each byte to the `control` stage. Delivery is a one-cycle `UART_valid` pulse with `UART_msg`, or a one-cycle `UART_err` pulse on a framing error. It sits directly upstream of `control`, and its three outputs connect straight to `control`'s `UART_valid`/`UART_err`/`UART_msg` inputs.

---
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver that oversamples the synchronised rx line.
// Each frame delivers either a one-cycle UART_valid pulse with the byte on
// UART_msg, or a one-cycle UART_err pulse when the stop bit samples low.
//
// Ports:
//   clk         system clock (single domain)
//   rstb        synchronous reset, active HIGH despite the name
//   rx          asynchronous serial input, idle high
//   UART_msg    last correctly received byte, held between frames
//   UART_valid  one-cycle pulse, new byte on UART_msg
//   UART_err    one-cycle pulse, framing error (stop bit low)
module uart_rx #(
    parameter int unsigned C_CLK_FRQ         = 100_000_000,
    parameter int unsigned C_UART_RATE       = 115_200,
    parameter int unsigned C_UART_DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         rx,
    output logic [C_UART_DATA_WIDTH-1:0] UART_msg,
    output logic                         UART_valid,
    output logic                         UART_err
);

    localparam int unsigned N     = C_CLK_FRQ / C_UART_RATE;
    localparam int unsigned H     = N / 2;
    localparam int unsigned W     = C_UART_DATA_WIDTH;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BIT_W = (W > 1) ? $clog2(W) : 1;

    // Compare values are one less than the interval: the counter is cleared
    // on the edge that enters a state, so it reads k-1 just before edge k.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [W-1:0]     msg_q, msg_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchroniser; resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rstb) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q <= S_WAIT_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            msg_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        msg_d   = msg_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            S_WAIT_IDLE: begin
                // Need a full bit time of continuous high before trusting the line.
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Mid start bit: a high sample here means the low was a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    // LSB first: after W shifts bit i sits at position i.
                    shift_d        = shift_q >> 1;
                    shift_d[W-1]   = rx_s;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        msg_d   = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_WAIT_IDLE;
            end
        endcase
    end

    assign UART_msg   = msg_q;
    assign UART_valid = valid_q;
    assign UART_err   = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at default parameters (868 clocks per bit).
module tb_uart_rx;

    localparam int NB        = 868;          // clocks per bit
    localparam int PULSE_LAT = 8249;         // drive of start bit -> pulse visible (P+8248, P = drive+1)
    localparam int FRAME     = 10 * NB;      // one 8N1 frame

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle;       // high cycles before the start bit
        int         low_tail;   // extra low cycles after the stop bit
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_msg;
        logic       b2b;        // check spacing against previous valid
    } vec_t;

    logic       clk;
    logic       rstb;
    logic       rx;
    logic [7:0] UART_msg;
    logic       UART_valid;
    logic       UART_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int last_valid_cyc = -1;
    int last_err_cyc   = -1;
    int viol     = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;
    logic rst_seen = 1'b1;

    vec_t vecs [5];

    uart_rx dut (
        .clk        (clk),
        .rstb       (rstb),
        .rx         (rx),
        .UART_msg   (UART_msg),
        .UART_valid (UART_valid),
        .UART_err   (UART_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rstb;
    end

    // Pulse bookkeeping and protocol watch, sampled on the falling edge.
    always @(negedge clk) begin
        if (UART_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (UART_err) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (UART_valid && UART_err) viol++;
        if (UART_valid && prev_v) viol++;
        if (UART_err && prev_e) viol++;
        if (rst_seen && (UART_valid || UART_err || UART_msg != 8'h00)) viol++;
        prev_v = UART_valid;
        prev_e = UART_err;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Hold rx at b for n clock edges; entered and left at posedge+1.
    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        int v0, e0, pv, t0;
        logic [7:0] d;
        if (v.idle > 0) drive_bit(1'b1, v.idle);
        v0 = n_valid;
        e0 = n_err;
        pv = last_valid_cyc;
        t0 = cyc;
        d  = v.data;
        drive_bit(1'b0, NB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], NB);
        drive_bit(v.stop, NB);
        if (v.low_tail > 0) drive_bit(1'b0, v.low_tail);
        check({name, "_valid_cnt"}, n_valid - v0, int'(v.exp_valid));
        check({name, "_err_cnt"}, n_err - e0, int'(v.exp_err));
        check({name, "_msg"}, int'(UART_msg), int'(v.exp_msg));
        if (v.exp_valid) check({name, "_valid_time"}, last_valid_cyc, t0 + PULSE_LAT);
        if (v.exp_err)   check({name, "_err_time"}, last_err_cyc, t0 + PULSE_LAT);
        if (v.b2b)       check({name, "_spacing"}, last_valid_cyc - pv, FRAME);
    endtask

    initial begin
        int vr, er, t6;
        logic [7:0] b33;
        vec_t vx;

        //          data   stop  idle  tail    v     e     msg    b2b
        vecs[0] = '{8'h7A, 1'b1, 0,    0,      1'b1, 1'b0, 8'h7A, 1'b0};
        vecs[1] = '{8'h91, 1'b1, 200,  0,      1'b1, 1'b0, 8'h91, 1'b0};
        vecs[2] = '{8'h6E, 1'b1, 0,    0,      1'b1, 1'b0, 8'h6E, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 200,  2 * NB, 1'b0, 1'b1, 8'h6E, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 900,  0,      1'b1, 1'b0, 8'h01, 1'b0};

        // Reset held with idle line.
        rstb = 1'b1;
        rx   = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_msg", int'(UART_msg), 0);
        check("rst_valid", int'(UART_valid), 0);
        check("rst_err", int'(UART_err), 0);

        // Low line right after release must not be taken as a start bit.
        rstb = 1'b0;
        drive_bit(1'b0, 2000);
        drive_bit(1'b1, 900);
        check("wait_idle_no_valid", n_valid, 0);
        check("wait_idle_no_err", n_err, 0);

        foreach (vecs[i]) apply_vec($sformatf("vec%0d", i), vecs[i]);

        // Short low glitch: start sample sees high, no pulse.
        vr = n_valid;
        er = n_err;
        drive_bit(1'b0, 200);
        drive_bit(1'b1, 600);
        check("glitch_no_valid", n_valid - vr, 0);
        check("glitch_no_err", n_err - er, 0);
        vx = '{8'h02, 1'b1, 0, 0, 1'b1, 1'b0, 8'h02, 1'b0};
        apply_vec("after_glitch", vx);

        // Reset pulse in the middle of data bit 3 of 0x33.
        b33 = 8'h33;
        drive_bit(1'b0, NB);
        for (int i = 0; i < 3; i++) drive_bit(b33[i], NB);
        rx = b33[3];
        repeat (400) @(posedge clk);
        #1;
        rstb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_msg", int'(UART_msg), 0);
        rstb = 1'b0;
        @(posedge clk);
        #1;
        drive_bit(b33[3], NB - 402);
        vr = n_valid;
        er = n_err;
        t6 = 0;
        for (int i = 4; i < 8; i++) begin
            if (i == 6) t6 = cyc;
            drive_bit(b33[i], NB);
        end
        drive_bit(1'b1, NB);
        check("rst_mid_no_valid", n_valid - vr, 0);
        check("rst_mid_no_err", n_err - er, 0);

        // Bits 4-5 of the abandoned frame re-qualify the line, so bit 6's falling
        // edge starts a fresh frame: data = bit7(0) then idle ones -> 0xFE.
        drive_bit(1'b1, 7 * NB);
        check("tail_frame_valid", n_valid - vr, 1);
        check("tail_frame_err", n_err - er, 0);
        check("tail_frame_msg", int'(UART_msg), 8'hFE);
        check("tail_frame_time", last_valid_cyc, t6 + PULSE_LAT);

        vx = '{8'hA5, 1'b1, 0, 0, 1'b1, 1'b0, 8'hA5, 1'b0};
        apply_vec("after_rst", vx);

        drive_bit(1'b1, 20);
        check("protocol_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
